// File: rtl/rfu_sum_drain_if.sv
// rfu_sum_drain_if: snapshot capture and lane stream bundle
// for the fusion-unit accumulator drain.
interface rfu_sum_drain_if #(
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
);
  logic             cap_valid;
  logic             cap_ready;
  logic [127:0]     cap_sum;
  logic [1:0]       cap_mode;
  logic             cap_signed;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [3:0]       out_lane;
  logic             out_last;
  logic             mode_err;
  logic [CNT_W-1:0] frames_done;

  modport master (
    output cap_valid, cap_sum, cap_mode,
    output cap_signed, abort, out_ready,
    input  cap_ready, out_valid, out_data,
    input  out_lane, out_last, mode_err,
    input  frames_done
  );

  modport slave (
    input  cap_valid, cap_sum, cap_mode,
    input  cap_signed, abort, out_ready,
    output cap_ready, out_valid, out_data,
    output out_lane, out_last, mode_err,
    output frames_done
  );
endinterface

// File: rtl/rfu_sum_drain.sv
// rfu_sum_drain: unpacks one 128b MAC accumulator snapshot
// into a stream of sign/zero-extended lanes, one per cycle.
module rfu_sum_drain #(
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  rfu_sum_drain_if.slave bus
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t           r_state;
  logic [127:0]     r_sum;
  logic [1:0]       r_mode;
  logic             r_signed;
  logic             r_cap_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [3:0]       r_out_lane;
  logic             r_out_last;
  logic             r_mode_err;
  logic [CNT_W-1:0] r_frames;
  logic [3:0]       w_next_lane;

  assign w_next_lane = r_out_lane + 4'd1;

  function automatic logic [OUT_W-1:0] f_lane(
    input logic [127:0] s,
    input logic [1:0]   m,
    input logic         sg,
    input logic [3:0]   i
  );
    logic [7:0]       b8;
    logic [11:0]      b12;
    logic [19:0]      b20;
    logic [OUT_W-1:0] r;
    b8  = s[{i, 3'b000} +: 8];
    b12 = s[7'(i[1:0]) * 7'd12 +: 12];
    b20 = s[19:0];
    r   = '0;
    case (m)
      2'b00: r = sg ? OUT_W'($signed(b8))
                    : OUT_W'(b8);
      2'b01: r = sg ? OUT_W'($signed(b12))
                    : OUT_W'(b12);
      2'b10: r = sg ? OUT_W'($signed(b20))
                    : OUT_W'(b20);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic f_last(
    input logic [1:0] m,
    input logic [3:0] i
  );
    logic l;
    l = 1'b0;
    case (m)
      2'b00:   l = (i == 4'd15);
      2'b01:   l = (i == 4'd3);
      2'b10:   l = (i == 4'd0);
      default: l = 1'b0;
    endcase
    return l;
  endfunction

  // Capture/stream FSM; all outputs registered, abort beats last-lane count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sum       <= '0;
      r_mode      <= '0;
      r_signed    <= 1'b0;
      r_cap_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_out_last  <= 1'b0;
      r_mode_err  <= 1'b0;
      r_frames    <= '0;
    end else begin
      r_mode_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cap_valid) begin
            r_sum    <= bus.cap_sum;
            r_mode   <= bus.cap_mode;
            r_signed <= bus.cap_signed;
            if (bus.cap_mode == 2'b11) begin
              r_mode_err <= 1'b1;
            end else begin
              r_state     <= STREAM;
              r_cap_ready <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_lane  <= '0;
              r_out_data  <= f_lane(bus.cap_sum,
                bus.cap_mode, bus.cap_signed, 4'd0);
              r_out_last  <= f_last(bus.cap_mode, 4'd0);
            end
          end
        end
        STREAM: begin
          if (bus.abort) begin
            r_state     <= IDLE;
            r_cap_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end else if (bus.out_ready) begin
            if (r_out_last) begin
              r_state     <= IDLE;
              r_cap_ready <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              if (r_frames != '1)
                r_frames <= r_frames + 1'b1;
            end else begin
              r_out_lane <= w_next_lane;
              r_out_data <= f_lane(r_sum, r_mode,
                r_signed, w_next_lane);
              r_out_last <= f_last(r_mode, w_next_lane);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cap_ready   = r_cap_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_lane    = r_out_lane;
  assign bus.out_last    = r_out_last;
  assign bus.mode_err    = r_mode_err;
  assign bus.frames_done = r_frames;

endmodule

// File: tb/tb_rfu_sum_drain.sv
// tb_rfu_sum_drain: directed vectors for the accumulator
// drain, counter width 2 so saturation is reachable.
module tb_rfu_sum_drain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rfu_sum_drain_if #(.OUT_W(32), .CNT_W(2)) bus ();

  rfu_sum_drain #(.OUT_W(32), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [127:0] s,
                         input logic [1:0] m,
                         input logic sg);
    bus.cap_valid  = 1'b1;
    bus.cap_sum    = s;
    bus.cap_mode   = m;
    bus.cap_signed = sg;
    tick();
    bus.cap_valid  = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 64'(bus.out_valid), 0);
    chk({tag, ".rdy"}, 64'(bus.cap_ready), 1);
    chk({tag, ".data"}, 64'(bus.out_data), 0);
    chk({tag, ".lane"}, 64'(bus.out_lane), 0);
    chk({tag, ".last"}, 64'(bus.out_last), 0);
    chk({tag, ".merr"}, 64'(bus.mode_err), 0);
    chk({tag, ".frm"}, 64'(bus.frames_done), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [127:0] s8;
  logic [31:0]  exp4 [4];
  logic [2:0]   rpat;
  int           e;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cap_valid  = 1'b0;
    bus.cap_sum    = '0;
    bus.cap_mode   = 2'b00;
    bus.cap_signed = 1'b0;
    bus.abort      = 1'b0;
    bus.out_ready  = 1'b1;
    s8 = '0;
    for (int i = 0; i < 16; i++)
      s8[8*i +: 8] = 8'h80 + 8'(i);
    tick();
    tick();
    rst = 1'b0;
    chk_reset("rst0");

    // 1x20b signed then unsigned
    capture(128'hFFFF6, 2'b10, 1'b1);
    chk("w20s.valid", 64'(bus.out_valid), 1);
    chk("w20s.data", 64'(bus.out_data), 64'hFFFFFFF6);
    chk("w20s.lane", 64'(bus.out_lane), 0);
    chk("w20s.last", 64'(bus.out_last), 1);
    chk("w20s.rdy", 64'(bus.cap_ready), 0);
    tick();
    chk("w20s.idle", 64'(bus.out_valid), 0);
    chk("w20s.rdy1", 64'(bus.cap_ready), 1);
    chk("w20s.frm", 64'(bus.frames_done), 1);
    capture(128'hFFFF6, 2'b10, 1'b0);
    chk("w20u.data", 64'(bus.out_data), 64'h000FFFF6);
    tick();
    chk("w20u.frm", 64'(bus.frames_done), 2);

    // 4x12b signed
    exp4[0] = 32'hFFFFFFFF;
    exp4[1] = 32'h00000001;
    exp4[2] = 32'h000007FF;
    exp4[3] = 32'hFFFFF800;
    capture(128'h800_7FF_001_FFF, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("w12.valid", 64'(bus.out_valid), 1);
      chk("w12.data", 64'(bus.out_data), 64'(exp4[i]));
      chk("w12.lane", 64'(bus.out_lane), 64'(i));
      chk("w12.last", 64'(bus.out_last), 64'(i == 3));
      tick();
    end
    chk("w12.idle", 64'(bus.out_valid), 0);
    chk("w12.frm", 64'(bus.frames_done), 3);

    // 16x8b signed, ready pattern 1,0,0 repeating
    rpat = 3'b001;
    capture(s8, 2'b00, 1'b1);
    e = 0;
    for (int k = 0; k < 64 && e < 16; k++) begin
      bus.out_ready = rpat[k % 3];
      chk("w8.valid", 64'(bus.out_valid), 1);
      chk("w8.lane", 64'(bus.out_lane), 64'(e));
      chk("w8.data", 64'(bus.out_data),
          64'(32'hFFFFFF80 + 32'(e)));
      chk("w8.last", 64'(bus.out_last), 64'(e == 15));
      chk("w8.rdy", 64'(bus.cap_ready), 0);
      tick();
      if (rpat[k % 3]) e++;
    end
    bus.out_ready = 1'b1;
    chk("w8.count", 64'(e), 16);
    chk("w8.idle", 64'(bus.out_valid), 0);
    chk("w8.frm", 64'(bus.frames_done), 3);

    // Illegal mode
    do_reset();
    chk_reset("rst1");
    capture(128'h1234, 2'b11, 1'b1);
    chk("ill.merr", 64'(bus.mode_err), 1);
    chk("ill.valid", 64'(bus.out_valid), 0);
    chk("ill.rdy", 64'(bus.cap_ready), 1);
    tick();
    chk("ill.merr0", 64'(bus.mode_err), 0);
    chk("ill.valid1", 64'(bus.out_valid), 0);
    chk("ill.frm", 64'(bus.frames_done), 0);

    // Abort on lane 5, input changes ignored mid-stream
    capture(s8, 2'b00, 1'b1);
    bus.cap_sum  = '1;
    bus.cap_mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      chk("ab.lane", 64'(bus.out_lane), 64'(i));
      chk("ab.data", 64'(bus.out_data),
          64'(32'hFFFFFF80 + 32'(i)));
      tick();
    end
    chk("ab.lane5", 64'(bus.out_lane), 5);
    bus.abort = 1'b1;
    tick();
    chk("ab.valid", 64'(bus.out_valid), 0);
    chk("ab.rdy", 64'(bus.cap_ready), 1);
    chk("ab.frm", 64'(bus.frames_done), 0);

    // Capture with abort held in IDLE, unsigned, reset on lane 9
    capture(s8, 2'b00, 1'b0);
    bus.abort = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("rs.valid", 64'(bus.out_valid), 1);
      chk("rs.data", 64'(bus.out_data),
          64'(32'h80 + 32'(i)));
      tick();
    end
    chk("rs.lane9", 64'(bus.out_lane), 9);
    do_reset();
    chk_reset("rst2");

    // Saturation at CNT_W=2
    for (int f = 1; f <= 5; f++) begin
      capture(128'h00055, 2'b10, 1'b0);
      tick();
      chk("sat.frm", 64'(bus.frames_done),
          64'((f > 3) ? 3 : f));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
